data_sram_slave: RTL



---
 rtl/data_sram_slave.sv | 132 +++++++++++++
 1 files changed

// File: rtl/data_sram_slave.sv
// In-order SRAM-like data-port responder backed by a word-addressed RAM.
// Up to DEPTH outstanding requests; one data_ok per accept, oldest first.
module data_sram_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 2,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        resp_stall,
  output logic        busy
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int WORDS = 1 << ADDR_WIDTH;

  localparam logic [2:0]    LAT  = 3'(LATENCY);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0] mem_q [WORDS];

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wr_q, wr_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [2:0]       age_q  [DEPTH];
  logic [2:0]       age_d  [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           ram_word;
  logic                  accept;
  logic                  retire;
  logic                  unused_addr;

  assign idx         = data_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^{data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};
  assign ram_word    = mem_q[idx];

  // No pass-through: a slot freed this cycle is only visible next cycle.
  assign data_addr_ok = !reset && (count_q < FULL);
  assign accept       = data_req && data_addr_ok;

  assign data_data_ok = !reset && valid_q[rptr_q]
                     && (age_q[rptr_q] >= LAT) && !resp_stall;
  assign retire       = data_data_ok;

  assign data_rdata = (data_data_ok && !wr_q[rptr_q])
                    ? data_q[rptr_q] : '0;

  assign busy = !reset && (count_q != '0);

  always_comb begin
    valid_d = valid_q;
    wr_d    = wr_q;
    data_d  = data_q;
    age_d   = age_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (age_q[i] < LAT)) begin
        age_d[i] = age_q[i] + 3'd1;
      end
    end

    if (retire) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
    end

    if (accept) begin
      valid_d[wptr_q] = 1'b1;
      wr_d[wptr_q]    = data_wr;
      data_d[wptr_q]  = data_wr ? '0 : ram_word;
      age_d[wptr_q]   = 3'd1;
      wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
    end

    case ({accept, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_q   <= wr_d;
    data_q <= data_d;
    age_q  <= age_d;
  end

  // RAM survives reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (accept && data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= data_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
